// File: rtl/headstage_pkg.sv
// Shared constants, FSM encoding and nibble-counter helper for the 4-bit frame link.
// Used by both the frame transmitter and the receiver.
package headstage_pkg;

   localparam int N_CH     = 32;
   localparam int SAMPLE_W = 16;
   localparam int WORDS_CH = 2;
   localparam int FRAME_W  = N_CH * SAMPLE_W * WORDS_CH;
   localparam int ID_W     = 8;
   localparam int HDR_NIB  = ID_W / 4;
   localparam int NIB_TOT  = (ID_W + FRAME_W) / 4;
   localparam int NIB_W    = $clog2(NIB_TOT + 1);

   typedef logic [NIB_W-1:0] nib_cnt_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HDR,
      ST_PAY,
      ST_DONE
   } rx_state_e;

   // Saturates at NIB_TOT+1 so overlong transfers stay distinguishable from good ones.
   function automatic nib_cnt_t nib_sat_inc(input nib_cnt_t n);
      return (n > nib_cnt_t'(NIB_TOT)) ? n : n + nib_cnt_t'(1);
   endfunction

endpackage

// File: rtl/qspi_frame_rx_if.sv
// Link pins plus received-frame outputs of the 4-bit frame receiver.
// master drives the link and observes results; slave is the receiver.
interface qspi_frame_rx_if;
   import headstage_pkg::*;

   logic               cs;
   logic               sclk;
   logic               data0;
   logic               data1;
   logic               data2;
   logic               data3;
   logic [FRAME_W-1:0] frame;
   logic [ID_W-1:0]    frame_id;
   logic               frame_valid;
   logic               len_err;
   logic               seq_err;
   logic [31:0]        frame_cnt;
   logic               busy;

   modport master (
      output cs, sclk, data0, data1, data2, data3,
      input  frame, frame_id, frame_valid, len_err, seq_err, frame_cnt, busy
   );

   modport slave (
      input  cs, sclk, data0, data1, data2, data3,
      output frame, frame_id, frame_valid, len_err, seq_err, frame_cnt, busy
   );

endinterface

// File: rtl/link_sync.sv
// W-bit multi-flop synchronizer with rise/fall detect on the synchronized level.
// Latency STAGES clk to q_o, edges valid in the same cycle as q_o; no backpressure.
module link_sync #(
   parameter int W      = 1,
   parameter int STAGES = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o,
   output logic [W-1:0] rise_o,
   output logic [W-1:0] fall_o
);

   logic [W-1:0] sync_q [STAGES];
   logic [W-1:0] prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGES; i++) begin
            sync_q[i] <= '0;
         end
         prev_q <= '0;
      end else begin
         sync_q[0] <= d_i;
         for (int i = 1; i < STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign q_o    = sync_q[STAGES-1];
   assign rise_o = q_o & ~prev_q;
   assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/qspi_frame_rx.sv
// Oversampling receiver for the 4-bit frame link: rebuilds {frame_id, frame}, flags length/sequence errors.
// frame_valid SYNC_STAGES+1 clk after the final sclk pin edge; no backpressure, consumers copy on the pulse.
module qspi_frame_rx
   import headstage_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   qspi_frame_rx_if.slave lnk
);

   logic       cs_rise;
   logic       cs_fall;
   logic       sclk_rise;
   logic [3:0] nib;
   logic       cs_lvl_unused;
   logic       sclk_lvl_unused;
   logic       sclk_fall_unused;
   logic [3:0] data_rise_unused;
   logic [3:0] data_fall_unused;

   link_sync #(.W(1), .STAGES(SYNC_STAGES)) u_cs_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .d_i    (lnk.cs),
      .q_o    (cs_lvl_unused),
      .rise_o (cs_rise),
      .fall_o (cs_fall)
   );

   link_sync #(.W(1), .STAGES(SYNC_STAGES)) u_sclk_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .d_i    (lnk.sclk),
      .q_o    (sclk_lvl_unused),
      .rise_o (sclk_rise),
      .fall_o (sclk_fall_unused)
   );

   // Data rides the same depth as sclk so nib is aligned with the sclk_rise cycle.
   link_sync #(.W(4), .STAGES(SYNC_STAGES)) u_data_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .d_i    ({lnk.data3, lnk.data2, lnk.data1, lnk.data0}),
      .q_o    (nib),
      .rise_o (data_rise_unused),
      .fall_o (data_fall_unused)
   );

   rx_state_e          state_q, state_d;
   nib_cnt_t           nib_q, nib_d;
   logic [ID_W-1:0]    id_sr_q, id_sr_d;
   logic [FRAME_W-1:0] pay_sr_q, pay_sr_d;
   logic [FRAME_W-1:0] frame_q, frame_d;
   logic [ID_W-1:0]    frame_id_q, frame_id_d;
   logic [ID_W-1:0]    prev_id_q, prev_id_d;
   logic               first_q, first_d;
   logic               fv_q, fv_d;
   logic               len_q, len_d;
   logic               seq_q, seq_d;
   logic [31:0]        cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         nib_q      <= '0;
         id_sr_q    <= '0;
         pay_sr_q   <= '0;
         frame_q    <= '0;
         frame_id_q <= '0;
         prev_id_q  <= '0;
         first_q    <= 1'b0;
         fv_q       <= 1'b0;
         len_q      <= 1'b0;
         seq_q      <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         nib_q      <= nib_d;
         id_sr_q    <= id_sr_d;
         pay_sr_q   <= pay_sr_d;
         frame_q    <= frame_d;
         frame_id_q <= frame_id_d;
         prev_id_q  <= prev_id_d;
         first_q    <= first_d;
         fv_q       <= fv_d;
         len_q      <= len_d;
         seq_q      <= seq_d;
         cnt_q      <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      nib_d      = nib_q;
      id_sr_d    = id_sr_q;
      pay_sr_d   = pay_sr_q;
      frame_d    = frame_q;
      frame_id_d = frame_id_q;
      prev_id_d  = prev_id_q;
      first_d    = first_q;
      fv_d       = 1'b0;
      len_d      = 1'b0;
      seq_d      = 1'b0;
      cnt_d      = cnt_q;

      unique case (state_q)
         ST_IDLE: begin
            if (cs_fall) begin
               state_d  = ST_HDR;
               nib_d    = '0;
               id_sr_d  = '0;
               pay_sr_d = '0;
            end
         end
         ST_HDR: begin
            if (sclk_rise) begin
               id_sr_d = {id_sr_q[ID_W-5:0], nib};
               nib_d   = nib_sat_inc(nib_q);
               if (nib_q == nib_cnt_t'(HDR_NIB - 1)) begin
                  state_d = ST_PAY;
               end
            end
         end
         ST_PAY: begin
            if (sclk_rise) begin
               pay_sr_d = {pay_sr_q[FRAME_W-5:0], nib};
               nib_d    = nib_sat_inc(nib_q);
               if (nib_q == nib_cnt_t'(NIB_TOT - 1)) begin
                  state_d    = ST_DONE;
                  frame_d    = pay_sr_d;
                  frame_id_d = id_sr_q;
                  fv_d       = 1'b1;
                  cnt_d      = cnt_q + 32'd1;
                  seq_d      = first_q && (id_sr_q != (prev_id_q + ID_W'(1)));
                  prev_id_d  = id_sr_q;
                  first_d    = 1'b1;
               end
            end
         end
         ST_DONE: begin
            if (sclk_rise) begin
               nib_d = nib_sat_inc(nib_q);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A rise seen in IDLE belongs to a transfer we never armed for (e.g. after reset).
      if (cs_rise && (state_q != ST_IDLE)) begin
         state_d = ST_IDLE;
         len_d   = (nib_d != nib_cnt_t'(NIB_TOT));
      end
   end

   assign lnk.frame       = frame_q;
   assign lnk.frame_id    = frame_id_q;
   assign lnk.frame_valid = fv_q;
   assign lnk.len_err     = len_q;
   assign lnk.seq_err     = seq_q;
   assign lnk.frame_cnt   = cnt_q;
   assign lnk.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_qspi_frame_rx.sv
// Directed bench for qspi_frame_rx: expected frames queued at stimulus time, popped by a pulse monitor.
module tb_qspi_frame_rx;
   import headstage_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   qspi_frame_rx_if lnk();

   qspi_frame_rx #(.SYNC_STAGES(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .lnk   (lnk)
   );

   typedef struct {
      logic [ID_W-1:0]    id;
      logic [FRAME_W-1:0] frm;
      logic               seq;
      logic [31:0]        cnt;
   } exp_t;

   exp_t exp_q[$];
   int   exp_len = 0;
   int   checks  = 0;
   int   errors  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic chk_frame(input string name, input logic [FRAME_W-1:0] act,
                            input logic [FRAME_W-1:0] req);
      int bad;
      bad = -1;
      checks++;
      for (int k = FRAME_W/16 - 1; k >= 0; k--) begin
         if (act[16*k +: 16] !== req[16*k +: 16]) bad = k;
      end
      if (bad >= 0) begin
         errors++;
         $display("FAIL %s: word %0d got %h expected %h", name, bad,
                  act[16*bad +: 16], req[16*bad +: 16]);
      end
   endtask

   // Word k = {seed, k}; seed 0 gives the plain ramp.
   function automatic logic [FRAME_W-1:0] make_frame(input logic [7:0] seed);
      logic [FRAME_W-1:0] f;
      for (int k = 0; k < FRAME_W/16; k++) f[16*k +: 16] = {seed, 8'(k)};
      return f;
   endfunction

   function automatic logic [3:0] nib_of(input logic [ID_W-1:0] id,
                                         input logic [FRAME_W-1:0] f, input int i);
      if (i < HDR_NIB) return id[ID_W-1-4*i -: 4];
      if (i < NIB_TOT) return f[FRAME_W-1-4*(i-HDR_NIB) -: 4];
      return 4'hA;
   endfunction

   task automatic put_nib(input logic [3:0] n, input int half, input bit cs_up);
      {lnk.data3, lnk.data2, lnk.data1, lnk.data0} = n;
      #(half);
      lnk.sclk = 1'b1;
      if (cs_up) lnk.cs = 1'b1;
      #(half);
      lnk.sclk = 1'b0;
   endtask

   task automatic send(input logic [ID_W-1:0] id, input logic [FRAME_W-1:0] f,
                       input int nnib, input int half, input bit cs_on_last);
      lnk.cs = 1'b0;
      #(half);
      for (int i = 0; i < nnib; i++) put_nib(nib_of(id, f, i), half, cs_on_last && (i == nnib - 1));
      if (!cs_on_last) begin
         #(half);
         lnk.cs = 1'b1;
      end
      #(8 * half);
   endtask

   task automatic expect_frame(input logic [ID_W-1:0] id, input logic [FRAME_W-1:0] f,
                               input logic seq, input logic [31:0] cnt);
      exp_t e;
      e.id  = id;
      e.frm = f;
      e.seq = seq;
      e.cnt = cnt;
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (lnk.frame_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_frame_valid", 32'(lnk.frame_valid), 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("frame_id", 32'(lnk.frame_id), 32'(e.id));
               chk_frame("frame", lnk.frame, e.frm);
               chk("seq_err", 32'(lnk.seq_err), 32'(e.seq));
               chk("frame_cnt", lnk.frame_cnt, e.cnt);
            end
         end else if (lnk.seq_err) begin
            chk("seq_err_without_valid", 32'(lnk.seq_err), 32'd0);
         end
         if (lnk.len_err) begin
            chk("len_err_expected", 32'(exp_len > 0), 32'd1);
            if (exp_len > 0) exp_len--;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, got no end of stimulus expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [ID_W-1:0]    ids  [4];
      logic               seqs [4];
      logic [FRAME_W-1:0] f;
      logic [FRAME_W-1:0] prev_f;

      ids  = '{8'hFE, 8'hFF, 8'h00, 8'h02};
      seqs = '{1'b0, 1'b0, 1'b0, 1'b1};

      lnk.cs    = 1'b1;
      lnk.sclk  = 1'b0;
      lnk.data0 = 1'b0;
      lnk.data1 = 1'b0;
      lnk.data2 = 1'b0;
      lnk.data3 = 1'b0;
      rst_n     = 1'b0;
      repeat (4) @(negedge clk);

      chk_frame("reset_frame", lnk.frame, '0);
      chk("reset_frame_id", 32'(lnk.frame_id), 32'd0);
      chk("reset_frame_valid", 32'(lnk.frame_valid), 32'd0);
      chk("reset_len_err", 32'(lnk.len_err), 32'd0);
      chk("reset_seq_err", 32'(lnk.seq_err), 32'd0);
      chk("reset_frame_cnt", lnk.frame_cnt, 32'd0);
      chk("reset_busy", 32'(lnk.busy), 32'd0);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);

      // Reset lands at nibble 100; the remainder of the burst must be ignored.
      f = make_frame(8'h33);
      lnk.cs = 1'b0;
      #40;
      for (int i = 0; i < 100; i++) put_nib(nib_of(8'h33, f, i), 40, 1'b0);
      chk("busy_mid_frame", 32'(lnk.busy), 32'd1);
      rst_n = 1'b0;
      #20;
      chk("busy_in_reset", 32'(lnk.busy), 32'd0);
      rst_n = 1'b1;
      for (int i = 100; i < NIB_TOT; i++) put_nib(nib_of(8'h33, f, i), 40, 1'b0);
      #40;
      lnk.cs = 1'b1;
      #320;
      chk("busy_after_aborted", 32'(lnk.busy), 32'd0);
      chk("cnt_after_aborted", lnk.frame_cnt, 32'd0);

      f = make_frame(8'h00);
      expect_frame(8'h05, f, 1'b0, 32'd1);
      send(8'h05, f, NIB_TOT, 40, 1'b0);
      chk("nominal_cnt", lnk.frame_cnt, 32'd1);
      chk("nominal_busy", 32'(lnk.busy), 32'd0);

      rst_n = 1'b0;
      #20;
      rst_n = 1'b1;
      #100;

      for (int s = 0; s < 4; s++) begin
         f = make_frame(ids[s]);
         expect_frame(ids[s], f, seqs[s], 32'(s + 1));
         send(ids[s], f, NIB_TOT, 40, 1'b0);
      end
      chk("seq_cnt", lnk.frame_cnt, 32'd4);
      prev_f = make_frame(8'h02);

      exp_len++;
      send(8'h03, make_frame(8'h77), 200, 40, 1'b0);
      chk_frame("short_keeps_frame", lnk.frame, prev_f);
      chk("short_keeps_id", 32'(lnk.frame_id), 32'h02);
      chk("short_cnt", lnk.frame_cnt, 32'd4);
      chk("short_len_seen", 32'(exp_len), 32'd0);

      f = make_frame(8'h03);
      expect_frame(8'h03, f, 1'b0, 32'd5);
      send(8'h03, f, NIB_TOT, 40, 1'b0);

      exp_len++;
      f = make_frame(8'h04);
      expect_frame(8'h04, f, 1'b0, 32'd6);
      send(8'h04, f, NIB_TOT + 2, 40, 1'b0);
      chk("long_len_seen", 32'(exp_len), 32'd0);

      f = make_frame(8'h05);
      expect_frame(8'h05, f, 1'b0, 32'd7);
      send(8'h05, f, NIB_TOT, 20, 1'b1);

      chk("frames_missing", 32'(exp_q.size()), 32'd0);
      chk("len_err_missing", 32'(exp_len), 32'd0);
      chk("final_cnt", lnk.frame_cnt, 32'd7);
      chk("final_busy", 32'(lnk.busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
